// File: rtl/mrv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mrv_mem_pkg
//  Description : Shared SRAM-port field widths and requester identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mrv_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 4;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mrv_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mrv_arb_pick
//  Description : Stateless requester selection for the i/d SRAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mrv_arb_pick
    import mrv_mem_pkg::*;
#(
    parameter int POLICY     = 0,
    parameter int MAX_CONSEC = 4
) (
    input  logic             i_req_i,
    input  logic             i_req_d,
    input  logic             i_last,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_sel
);

    localparam logic [CNT_W-1:0] c_max_consec = CNT_W'(MAX_CONSEC);

    always_comb begin
        o_sel = i_last;
        if (i_req_i && i_req_d) begin
            if (POLICY == 1) begin
                o_sel = ~i_last;
            end else begin
                // data wins until i has watched MAX_CONSEC d grants go by
                o_sel = (i_cnt == c_max_consec) ? REQ_I : REQ_D;
            end
        end else if (i_req_i) begin
            o_sel = REQ_I;
        end else if (i_req_d) begin
            o_sel = REQ_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mrv_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mrv_sram_arbiter
//  Description : Shares one SRAM-style downstream port between i and d ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module mrv_sram_arbiter
    import mrv_mem_pkg::*;
#(
    parameter int POLICY     = 0,
    parameter int MAX_CONSEC = 4
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              i_cen,
    input  logic              i_wen,
    input  logic [STRB_W-1:0] i_strb,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    output logic              i_error,
    input  logic              d_cen,
    input  logic              d_wen,
    input  logic [STRB_W-1:0] d_strb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              d_error,
    output logic              m_cen,
    output logic              m_wen,
    output logic [STRB_W-1:0] m_strb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_stall,
    input  logic              m_error,
    output logic              grant_d
);

    localparam logic [CNT_W-1:0] c_max_consec = CNT_W'(MAX_CONSEC);

    logic             r_locked;
    logic             r_owner;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;

    logic w_pick;
    logic w_sel;
    logic w_sel_cen;
    logic w_done;

    mrv_arb_pick #(
        .POLICY     (POLICY),
        .MAX_CONSEC (MAX_CONSEC)
    ) u_pick (
        .i_req_i (i_cen),
        .i_req_d (d_cen),
        .i_last  (r_last),
        .i_cnt   (r_cnt),
        .o_sel   (w_pick)
    );

    assign w_sel     = r_locked ? r_owner : w_pick;
    assign w_sel_cen = (w_sel == REQ_D) ? d_cen : i_cen;
    assign w_done    = w_sel_cen && !m_stall;

    assign m_cen   = w_sel_cen && !g_reset;
    assign m_wen   = (w_sel == REQ_D) ? d_wen   : i_wen;
    assign m_strb  = (w_sel == REQ_D) ? d_strb  : i_strb;
    assign m_addr  = (w_sel == REQ_D) ? d_addr  : i_addr;
    assign m_wdata = (w_sel == REQ_D) ? d_wdata : i_wdata;
    assign grant_d = (w_sel == REQ_D) && !g_reset;

    // the losing side is held off only while it is actually asking
    assign i_stall = g_reset || ((w_sel == REQ_I) ? m_stall : i_cen);
    assign d_stall = g_reset || ((w_sel == REQ_D) ? m_stall : d_cen);
    assign i_error = !g_reset && (w_sel == REQ_I) && m_error;
    assign d_error = !g_reset && (w_sel == REQ_D) && m_error;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_locked <= 1'b0;
            r_owner  <= REQ_I;
            r_last   <= REQ_I;
            r_cnt    <= '0;
        end else if (r_locked && !w_sel_cen) begin
            // owner abandoned its request mid-transaction: just drop the lock
            r_locked <= 1'b0;
        end else if (w_sel_cen && m_stall) begin
            if (!r_locked) begin
                r_locked <= 1'b1;
                r_owner  <= w_sel;
            end
        end else if (w_done) begin
            r_locked <= 1'b0;
            r_last   <= w_sel;
            if ((w_sel == REQ_D) && i_cen) begin
                r_cnt <= (r_cnt == c_max_consec) ? r_cnt : r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
